lizard_collision: RTL

- Collision-detection stage directly upstream of the lizard enemy datapath; produces the 2-bit collision vector the lizard consumes.
- On each start pulse it latches the packed lizard state and predicts next-step x.
- It checks screen bounds, then probes a synchronous tile-map ROM at the leading edge (wall, two rows) and below the leading foot (ledge).
- Result is registered and held until the next evaluation.

---
 rtl/lizard_collision.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lizard_collision.sv
// Collision stage ahead of the lizard enemy datapath: predicts next-step x,
// checks screen bounds, then probes the tile map for a wall or a missing ledge.
module lizard_collision #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 20,
  parameter int LIZ_W      = 32,
  parameter int LIZ_H      = 32,
  parameter bit EDGE_TURN  = 1'b1
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] lizardState,
  output logic [8:0]  tile_addr,
  output logic        tile_rd,
  input  logic [3:0]  tile_data,
  output logic [1:0]  lizardCol,
  output logic        busy,
  output logic        done,
  output logic [2:0]  stateDbg
);

  // Handshake: start is honoured only in IDLE (never queued); busy is high
  // from the cycle after start until the done cycle; done is a one-cycle
  // pulse with lizardCol valid in it. tile_rd/tile_addr are presented for one
  // cycle and tile_data is expected exactly one cycle later.

  typedef enum logic [2:0] {IDLE, CALC, P0, P1, P2, WAIT, DONE} stateT;

  stateT       state;
  logic [9:0]  xPos;
  logic [9:0]  yPos;
  logic [4:0]  spd;
  logic        dir;
  logic [9:0]  px;
  logic        oob;
  logic        wall0;
  logic        wall1;
  logic        footEmpty;

  logic [10:0] py0;
  logic [10:0] py1;
  logic [10:0] py2;
  logic        off0;
  logic        off1;
  logic        off2;
  logic [10:0] rightEdge;
  logic        leftOob;
  logic        rightOob;
  logic        calcOob;
  logic [9:0]  pxCalc;
  logic        tileSolid;
  logic        hit;
  logic        unusedBits;

  assign unusedBits = ^{lizardState[6:2], lizardState[0]};
  assign stateDbg   = state;

  // Probe rows: top of sprite, bottom of sprite, and one pixel below the foot.
  assign py0  = {1'b0, yPos};
  assign py1  = py0 + 11'(LIZ_H - 1);
  assign py2  = py0 + 11'(LIZ_H);
  assign off0 = (py0 >= 11'(SCREEN_H));
  assign off1 = (py1 >= 11'(SCREEN_H));
  assign off2 = (py2 >= 11'(SCREEN_H));

  // 11-bit sum cannot wrap for any 10-bit x plus 5-bit speed plus sprite width.
  assign rightEdge = {1'b0, xPos} + {6'b0, spd} + 11'(LIZ_W - 1);
  assign leftOob   = (xPos < {5'b0, spd});
  assign rightOob  = (rightEdge > 11'(SCREEN_W - 1));
  assign calcOob   = dir ? rightOob : leftOob;
  assign pxCalc    = dir ? rightEdge[9:0] : (xPos - {5'b0, spd});

  assign tileSolid = (tile_data != 4'd0);
  assign hit       = oob | wall0 | wall1 | (EDGE_TURN & footEmpty);

  function automatic logic [8:0] probeAddr(input logic [9:0] x, input logic [10:0] y);
    logic [10:0] row;
    logic [10:0] col;
    row = y >> TILE_SHIFT;
    col = {1'b0, x} >> TILE_SHIFT;
    return 9'(row * 11'(MAP_COLS) + col);
  endfunction

  always_ff @(posedge sim_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      xPos      <= '0;
      yPos      <= '0;
      spd       <= '0;
      dir       <= 1'b0;
      px        <= '0;
      oob       <= 1'b0;
      wall0     <= 1'b0;
      wall1     <= 1'b0;
      footEmpty <= 1'b0;
      tile_addr <= '0;
      tile_rd   <= 1'b0;
      lizardCol <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      tile_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xPos      <= lizardState[31:22];
            yPos      <= lizardState[21:12];
            spd       <= lizardState[11:7];
            dir       <= lizardState[1];
            oob       <= 1'b0;
            wall0     <= 1'b0;
            wall1     <= 1'b0;
            footEmpty <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (calcOob) begin
            oob   <= 1'b1;
            state <= DONE;
          end else begin
            px        <= pxCalc;
            tile_addr <= probeAddr(pxCalc, py0);
            tile_rd   <= !off0;
            state     <= P0;
          end
        end
        P0: begin
          tile_addr <= probeAddr(px, py1);
          tile_rd   <= !off1;
          state     <= P1;
        end
        P1: begin
          // An off-screen probe never reads the map; it counts as solid.
          wall0 <= off0 | tileSolid;
          if (EDGE_TURN) begin
            tile_addr <= probeAddr(px, py2);
            tile_rd   <= !off2;
            state     <= P2;
          end else begin
            state <= WAIT;
          end
        end
        P2: begin
          wall1 <= off1 | tileSolid;
          state <= WAIT;
        end
        WAIT: begin
          if (EDGE_TURN) begin
            footEmpty <= !(off2 | tileSolid);
          end else begin
            wall1 <= off1 | tileSolid;
          end
          state <= DONE;
        end
        DONE: begin
          lizardCol <= {dir & hit, ~dir & hit};
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
